// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// One 32-bit adder stage is reused across WORDS cycles, LSW first, with the
// carry chained word to word. Subtraction is A + ~B + 1.
module mp_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   a_in,
    input  logic [32*WORDS-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IDXW+4:0]  off_c;
    logic [31:0]      word_a_c;
    logic [31:0]      word_b_c;
    logic [32:0]      sum_c;
    logic             last_c;

    // Single shared 32-bit adder on the currently selected word
    always_comb begin
        off_c    = {idx_q, 5'b0};
        word_a_c = 32'(a_q >> off_c);
        word_b_c = 32'(b_q >> off_c);
        sum_c    = {1'b0, word_a_c} + {1'b0, word_b_c} + 33'(carry_q);
        last_c   = (idx_q == IDXW'(WORDS - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = sub ? ~b_in : b_in;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            S_RUN: begin
                result_d[off_c +: 32] = sum_c[31:0];
                carry_d               = sum_c[32];
                idx_d                 = idx_q + IDXW'(1);
                if (last_c) begin
                    // idx returns to 0 so it never exceeds WORDS-1
                    idx_d  = '0;
                    cout_d = sum_c[32];
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (sum_c[31] != a_q[W-1]);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4) against a wide-arithmetic model.
module tb_mp_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain full-width arithmetic
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic o);
        logic [W:0] full;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[W-1:0];
            c    = full[W];
            o    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = a - b;
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One operation with latency, busy-length, result and hold checks
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        int           cycles;
        int           busy_cycles;
        model(s, a, b, er, ec, eo);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        sub   = ~s;
        a_in  = rand_wide();
        b_in  = rand_wide();
        busy_cycles = busy ? 1 : 0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cycles++;
        end
        check({tag, ".latency"}, W'(cycles), W'(WORDS));
        check({tag, ".busy_len"}, W'(busy_cycles), W'(WORDS));
        check({tag, ".result"}, result, er);
        check({tag, ".cout"}, W'(cout), W'(ec));
        check({tag, ".ovf"}, W'(ovf), W'(eo));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, W'(done), W'(0));
        check({tag, ".hold"}, result, er);
    endtask

    initial begin
        logic [W-1:0] a1, b1, a2, b2, er;
        logic         ec, eo, s2;
        int           k;
        logic         seen;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", W'(busy), W'(0));
        check("reset.done", W'(done), W'(0));
        check("reset.result", result, W'(0));
        check("reset.cout", W'(cout), W'(0));
        check("reset.ovf", W'(ovf), W'(0));
        rst = 1'b0;

        // Directed boundary cases
        run_op("ripple", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1));
        check("ripple.const", result, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
        run_op("wrap", 1'b0, {W{1'b1}}, W'(1));
        check("wrap.const", result, W'(0));
        run_op("borrow", 1'b1, W'(5), W'(7));
        check("borrow.const", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        run_op("sub_pos", 1'b1, W'(7), W'(5));
        run_op("ovf_add", 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1));
        run_op("ovf_sub", 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, W'(1));
        run_op("sub_eq", 1'b1, 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0,
               128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            a1 = rand_wide();
            b1 = rand_wide();
            if (i % 6 == 1) b1 = ~a1;
            if (i % 6 == 3) b1 = a1;
            run_op("rand", 1'(i % 2), a1, b1);
        end

        // Start held through RUN/DONE: ignored, then accepted on the IDLE edge
        a1 = rand_wide(); b1 = rand_wide();
        a2 = rand_wide(); b2 = rand_wide(); s2 = 1'b1;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a_in = a1; b_in = b1;
        @(posedge clk);
        #1;
        sub = s2; a_in = a2; b_in = b2;
        k = 0;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        model(1'b0, a1, b1, er, ec, eo);
        check("hs.first_latency", W'(k), W'(WORDS));
        check("hs.first_result", result, er);
        @(posedge clk);
        #1;
        check("hs.single_pulse", W'(done), W'(0));
        k = 0;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        start = 1'b0;
        check("hs.second_gap", W'(k), W'(WORDS + 1));
        model(s2, a2, b2, er, ec, eo);
        check("hs.second_result", result, er);
        check("hs.second_cout", W'(cout), W'(ec));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("hs.no_third", W'(busy), W'(0));

        // Reset while idx==2
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a_in = {W{1'b1}}; b_in = W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid.busy", W'(busy), W'(0));
        check("rstmid.done", W'(done), W'(0));
        check("rstmid.result", result, W'(0));
        check("rstmid.cout", W'(cout), W'(0));
        check("rstmid.ovf", W'(ovf), W'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("rstmid.no_done", W'(seen), W'(0));
        run_op("after_rst", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
